branch_update_queue: RTL and testbench

In-order tracking queue for predicted branches. It sits between fetch/execute and the local-history predictor and drives the predictor's update ports (`branch_valid1/2`, `branch_pc1/2`, `branch_result1/2`). Fetch allocates up to two branches per cycle with their predicted direction. Execute resolves them out of order by tag. The queue retires resolved branches in program order, up to two per cycle, and flags mispredictions with a flush of all younger entries.

---
 rtl/branch_update_queue.sv | 167 ++++++++++++++++
 tb/tb_branch_update_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// Purpose: in-order queue of predicted branches; retires resolved ones (up to 2/cycle) to the predictor.
// Latency: allocation is visible next cycle; a resolution at the head retires combinationally the following cycle.
// Backpressure: bq_full (fewer than 2 free) drops all allocations that cycle, so fetch must stall.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   alloc{1,2}_*            - fetch allocation (slot 2 is younger); alloc{1,2}_tag give the assigned tags
//   bq_full, bq_empty       - combinational occupancy flags
//   ex_{valid,tag,taken}{1,2} - out-of-order resolutions by tag (port 2 wins on a tag collision)
//   branch_{valid,pc,result}{1,2} - predictor update, oldest first
//   mispredict, mispredict_pc, mispredict_taken - flush pulse and the offending branch
//   stat_retired, stat_mispred - saturating counters, built only when BQ_STATS_EN is defined
module branch_update_queue #(
  parameter  int DEPTH = 8,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc1_valid,
  input  logic [63:0]   alloc1_pc,
  input  logic          alloc1_pred,
  input  logic          alloc2_valid,
  input  logic [63:0]   alloc2_pc,
  input  logic          alloc2_pred,
  output logic [TW-1:0] alloc1_tag,
  output logic [TW-1:0] alloc2_tag,
  output logic          bq_full,
  output logic          bq_empty,
  input  logic          ex_valid1,
  input  logic [TW-1:0] ex_tag1,
  input  logic          ex_taken1,
  input  logic          ex_valid2,
  input  logic [TW-1:0] ex_tag2,
  input  logic          ex_taken2,
  output logic          branch_valid1,
  output logic [63:0]   branch_pc1,
  output logic          branch_result1,
  output logic          branch_valid2,
  output logic [63:0]   branch_pc2,
  output logic          branch_result2,
  output logic          mispredict,
  output logic [63:0]   mispredict_pc,
  output logic          mispredict_taken,
  output logic [31:0]   stat_retired,
  output logic [31:0]   stat_mispred
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_resolved;
  logic [DEPTH-1:0] ent_pred;
  logic [DEPTH-1:0] ent_taken;
  logic [63:0]      ent_pc [DEPTH];

  logic [TW-1:0] head;
  logic [TW-1:0] tail;
  logic [TW:0]   count;

  logic [TW-1:0] head_p1;
  logic          ret1, ret2, mis1, mis2, flush;
  logic [1:0]    n_ret, n_alloc;
  logic          alloc_ok, do_a1, do_a2;

  always_comb begin
    head_p1  = head + TW'(1);
    ret1     = ent_valid[head] & ent_resolved[head];
    mis1     = ret1 & (ent_pred[head] ^ ent_taken[head]);
    // The second slot must not retire past a mispredict: it is on the wrong path.
    ret2     = ret1 & ~mis1 & ent_valid[head_p1] & ent_resolved[head_p1];
    mis2     = ret2 & (ent_pred[head_p1] ^ ent_taken[head_p1]);
    flush    = mis1 | mis2;
    n_ret    = {1'b0, ret1} + {1'b0, ret2};

    bq_full  = count > (TW+1)'(DEPTH - 2);
    bq_empty = count == '0;

    alloc_ok = ~bq_full & ~flush;
    do_a1    = alloc1_valid & alloc_ok;
    do_a2    = alloc2_valid & alloc_ok;
    n_alloc  = {1'b0, do_a1} + {1'b0, do_a2};

    alloc1_tag = tail;
    alloc2_tag = alloc1_valid ? tail + TW'(1) : tail;

    branch_valid1  = ret1;
    branch_pc1     = ret1 ? ent_pc[head] : 64'd0;
    branch_result1 = ret1 & ent_taken[head];
    branch_valid2  = ret2;
    branch_pc2     = ret2 ? ent_pc[head_p1] : 64'd0;
    branch_result2 = ret2 & ent_taken[head_p1];

    mispredict       = flush;
    mispredict_pc    = mis1 ? ent_pc[head] : (mis2 ? ent_pc[head_p1] : 64'd0);
    mispredict_taken = mis1 ? ent_taken[head] : (mis2 & ent_taken[head_p1]);
  end

  // Updates are ordered so later statements override earlier ones:
  // resolve (port 1, then port 2), then pop/flush, then allocate.
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid    <= '0;
      ent_resolved <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ex_valid1 && ex_tag1 == TW'(i) && ent_valid[i]) begin
          ent_resolved[i] <= 1'b1;
          ent_taken[i]    <= ex_taken1;
        end
        if (ex_valid2 && ex_tag2 == TW'(i) && ent_valid[i]) begin
          ent_resolved[i] <= 1'b1;
          ent_taken[i]    <= ex_taken2;
        end
        // A flush empties the whole queue: older entries are retiring, younger ones are squashed.
        if (flush || (ret1 && head == TW'(i)) || (ret2 && head_p1 == TW'(i))) begin
          ent_valid[i]    <= 1'b0;
          ent_resolved[i] <= 1'b0;
        end
        if (do_a1 && tail == TW'(i)) begin
          ent_valid[i]    <= 1'b1;
          ent_resolved[i] <= 1'b0;
          ent_pc[i]       <= alloc1_pc;
          ent_pred[i]     <= alloc1_pred;
        end
        if (do_a2 && alloc2_tag == TW'(i)) begin
          ent_valid[i]    <= 1'b1;
          ent_resolved[i] <= 1'b0;
          ent_pc[i]       <= alloc2_pc;
          ent_pred[i]     <= alloc2_pred;
        end
      end
      head <= head + TW'(n_ret);
      if (flush) begin
        tail  <= head + TW'(n_ret);
        count <= '0;
      end else begin
        tail  <= tail + TW'(n_alloc);
        count <= count + (TW+1)'(n_alloc) - (TW+1)'(n_ret);
      end
    end
  end

`ifdef BQ_STATS_EN
  logic [32:0] ret_sum;

  always_comb begin
    ret_sum = {1'b0, stat_retired} + 33'(n_ret);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_retired <= '0;
      stat_mispred <= '0;
    end else begin
      stat_retired <= ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
      if (flush && stat_mispred != 32'hFFFF_FFFF) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`else
  assign stat_retired = 32'd0;
  assign stat_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          alloc1_valid, alloc1_pred, alloc2_valid, alloc2_pred;
  logic [63:0]   alloc1_pc, alloc2_pc;
  logic [TW-1:0] alloc1_tag, alloc2_tag;
  logic          bq_full, bq_empty;
  logic          ex_valid1, ex_taken1, ex_valid2, ex_taken2;
  logic [TW-1:0] ex_tag1, ex_tag2;
  logic          branch_valid1, branch_result1, branch_valid2, branch_result2;
  logic [63:0]   branch_pc1, branch_pc2;
  logic          mispredict, mispredict_taken;
  logic [63:0]   mispredict_pc;
  logic [31:0]   stat_retired, stat_mispred;

  int n_checks = 0;
  int n_errors = 0;

  branch_update_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alloc1_valid(alloc1_valid), .alloc1_pc(alloc1_pc), .alloc1_pred(alloc1_pred),
    .alloc2_valid(alloc2_valid), .alloc2_pc(alloc2_pc), .alloc2_pred(alloc2_pred),
    .alloc1_tag(alloc1_tag), .alloc2_tag(alloc2_tag),
    .bq_full(bq_full), .bq_empty(bq_empty),
    .ex_valid1(ex_valid1), .ex_tag1(ex_tag1), .ex_taken1(ex_taken1),
    .ex_valid2(ex_valid2), .ex_tag2(ex_tag2), .ex_taken2(ex_taken2),
    .branch_valid1(branch_valid1), .branch_pc1(branch_pc1), .branch_result1(branch_result1),
    .branch_valid2(branch_valid2), .branch_pc2(branch_pc2), .branch_result2(branch_result2),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc), .mispredict_taken(mispredict_taken),
    .stat_retired(stat_retired), .stat_mispred(stat_mispred)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alloc1_valid = 0; alloc1_pc = 0; alloc1_pred = 0;
    alloc2_valid = 0; alloc2_pc = 0; alloc2_pred = 0;
    ex_valid1 = 0; ex_tag1 = 0; ex_taken1 = 0;
    ex_valid2 = 0; ex_tag2 = 0; ex_taken2 = 0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after inputs change, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic alloc_pair(input logic [63:0] pc1, input logic p1, input logic [63:0] pc2, input logic p2);
    alloc1_valid = 1; alloc1_pc = pc1; alloc1_pred = p1;
    alloc2_valid = 1; alloc2_pc = pc2; alloc2_pred = p2;
  endtask

  task automatic resolve1(input logic [TW-1:0] t, input logic tk);
    ex_valid1 = 1; ex_tag1 = t; ex_taken1 = tk;
  endtask

  task automatic resolve2(input logic [TW-1:0] t, input logic tk);
    ex_valid2 = 1; ex_tag2 = t; ex_taken2 = tk;
  endtask

  logic [TW-1:0] exp_tag;
  logic [TW-1:0] t_a, t_b;

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();

    // Reset / idle
    check("rst_empty", bq_empty, 1);
    check("rst_full", bq_full, 0);
    check("rst_bv1", branch_valid1, 0);
    check("rst_bv2", branch_valid2, 0);
    check("rst_mis", mispredict, 0);
    check("rst_stat_ret", stat_retired, 0);
    check("rst_tag1", alloc1_tag, 0);
    tick();

    // Two branches, resolved out of order
    alloc_pair(64'h100, 1, 64'h104, 0);
    settle();
    check("t2_tag1", alloc1_tag, 0);
    check("t2_tag2", alloc2_tag, 1);
    tick();
    resolve1(1, 0);
    settle();
    check("t2_notempty", bq_empty, 0);
    check("t2_hold_a", branch_valid1, 0);
    tick();
    resolve1(0, 1);
    settle();
    check("t2_hold_b", branch_valid1, 0);
    tick();
    check("t2_bv1", branch_valid1, 1);
    check("t2_pc1", branch_pc1, 64'h100);
    check("t2_res1", branch_result1, 1);
    check("t2_bv2", branch_valid2, 1);
    check("t2_pc2", branch_pc2, 64'h104);
    check("t2_res2", branch_result2, 0);
    check("t2_mis", mispredict, 0);
    tick();
    check("t2_once", branch_valid1, 0);
    check("t2_empty", bq_empty, 1);

    // Four entries (tags 2..5), second one mispredicts; younger entries flushed
    alloc_pair(64'h200, 0, 64'h204, 0);
    settle();
    check("t3_tag1", alloc1_tag, 2);
    tick();
    alloc_pair(64'h208, 0, 64'h20C, 0);
    tick();
    resolve1(3, 1);
    resolve2(2, 0);
    tick();
    resolve1(4, 0); // aimed at an entry that is being flushed
    settle();
    check("t3_bv1", branch_valid1, 1);
    check("t3_pc1", branch_pc1, 64'h200);
    check("t3_bv2", branch_valid2, 1);
    check("t3_pc2", branch_pc2, 64'h204);
    check("t3_res2", branch_result2, 1);
    check("t3_mis", mispredict, 1);
    check("t3_mis_pc", mispredict_pc, 64'h204);
    check("t3_mis_tk", mispredict_taken, 1);
    tick();
    check("t3_empty", bq_empty, 1);
    check("t3_nobv", branch_valid1, 0);
    check("t3_tail", alloc1_tag, 4);
    tick();
    check("t3_flushed_res", branch_valid1, 0);

    // Mispredict together with a new allocation
    alloc1_valid = 1; alloc1_pc = 64'h300; alloc1_pred = 1;
    tick();
    resolve1(4, 0);
    tick();
    alloc1_valid = 1; alloc1_pc = 64'h310; alloc1_pred = 0;
    settle();
    check("t5_mis", mispredict, 1);
    check("t5_mis_pc", mispredict_pc, 64'h300);
    check("t5_mis_tk", mispredict_taken, 0);
    check("t5_bv1", branch_valid1, 1);
    tick();
    check("t5_empty", bq_empty, 1);
    check("t5_tail", alloc1_tag, 5);
    resolve1(5, 0); // would retire 0x310 if the allocation had been kept
    tick();
    check("t5_dropped", branch_valid1, 0);

    // Fill to DEPTH-1 entries starting at tag 5
    for (int k = 0; k < 6; k += 2) begin
      alloc_pair(64'h400 + 64'(4*k), 0, 64'h400 + 64'(4*(k+1)), 0);
      tick();
    end
    check("t4_full_at6", bq_full, 0);
    alloc1_valid = 1; alloc1_pc = 64'h418; alloc1_pred = 0;
    tick();
    check("t4_full_at7", bq_full, 1);
    check("t4_tail", alloc1_tag, 4);
    alloc_pair(64'h500, 0, 64'h504, 0);
    tick();
    check("t4_full_hold", bq_full, 1);
    check("t4_tail_hold", alloc1_tag, 4);
    // Drain: resolve two per cycle in order, retirements lag by one cycle
    for (int j = 0; j < 5; j++) begin
      if (2*j < 7) begin t_a = TW'(5 + 2*j); resolve1(t_a, 0); end
      if (2*j + 1 < 7) begin t_b = TW'(5 + 2*j + 1); resolve2(t_b, 0); end
      settle();
      if (j >= 1) begin
        check("t4_drain_bv1", branch_valid1, 1);
        check("t4_drain_pc1", branch_pc1, 64'h400 + 64'(4*(2*j-2)));
        if (2*j - 1 < 7) check("t4_drain_pc2", branch_pc2, 64'h400 + 64'(4*(2*j-1)));
        else check("t4_drain_bv2", branch_valid2, 0);
      end
      tick();
    end
    check("t4_empty", bq_empty, 1);

    // Pointer wrap: DEPTH+3 single allocate/retire rounds starting at tag 4
    exp_tag = 3'd4;
    for (int i = 0; i < DEPTH + 3; i++) begin
      alloc1_valid = 1; alloc1_pc = 64'h600 + 64'(4*i); alloc1_pred = 1'(i);
      settle();
      check("wrap_tag", alloc1_tag, exp_tag);
      tick();
      resolve1(exp_tag, 1'(i));
      tick();
      check("wrap_bv1", branch_valid1, 1);
      check("wrap_pc1", branch_pc1, 64'h600 + 64'(4*i));
      check("wrap_mis", mispredict, 0);
      tick();
      exp_tag = exp_tag + 3'd1;
    end
    check("wrap_tail", alloc1_tag, 7);

    // Reset with 5 pending entries (tags 7,0,1,2,3), two non-head resolved
    alloc_pair(64'h800, 0, 64'h804, 0);
    tick();
    alloc_pair(64'h808, 0, 64'h80C, 0);
    tick();
    alloc1_valid = 1; alloc1_pc = 64'h810; alloc1_pred = 0;
    tick();
    resolve1(0, 0);
    resolve2(1, 1);
    tick();
    check("t6_pend", branch_valid1, 0);
    reset = 1;
    resolve1(7, 0);
    tick();
    reset = 0;
    settle();
    check("t6_empty", bq_empty, 1);
    check("t6_bv1", branch_valid1, 0);
    check("t6_tag", alloc1_tag, 0);
    tick();
    check("t6_bv1_late", branch_valid1, 0);
    check("t6_mis", mispredict, 0);
    check("t6_stat", stat_retired, 0);

    // Statistics: 3 retired, 1 mispredicted
    alloc_pair(64'h700, 0, 64'h704, 0);
    tick();
    alloc1_valid = 1; alloc1_pc = 64'h708; alloc1_pred = 0;
    tick();
    resolve1(0, 0);
    resolve2(1, 0);
    tick();
    resolve1(2, 1);
    settle();
    check("t7_bv2", branch_valid2, 1);
    tick();
    check("t7_mis", mispredict, 1);
    check("t7_mis_pc", mispredict_pc, 64'h708);
    tick();
`ifdef BQ_STATS_EN
    check("t7_stat_ret", stat_retired, 3);
    check("t7_stat_mis", stat_mispred, 1);
`else
    check("t7_stat_ret_off", stat_retired, 0);
    check("t7_stat_mis_off", stat_mispred, 0);
`endif
    check("t7_empty", bq_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
